// File: rtl/sqrt_share_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined sqrt between NUM_REQ requesters.
// Optional per-requester grant counters: define SQRT_SHARE_ARB_GRANT_CNT_EN.
module sqrt_share_arbiter #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned DATA_SIZE    = 17,
  parameter int unsigned SQRT_LATENCY = (DATA_SIZE + 1) / 2,
  parameter int unsigned ROOT_W       = (DATA_SIZE + 1) / 2
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic [NUM_REQ*(DATA_SIZE+1)-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  output logic [NUM_REQ-1:0]              o_req_ready,
  output logic [DATA_SIZE:0]              o_sqrt_data,
  output logic                            o_sqrt_data_ready,
  input  logic [ROOT_W-1:0]               i_sqrt_data,
  input  logic                            i_sqrt_data_ready,
  output logic [NUM_REQ*ROOT_W-1:0]       o_res_data,
  output logic [NUM_REQ-1:0]              o_res_valid,
`ifdef SQRT_SHARE_ARB_GRANT_CNT_EN
  output logic [NUM_REQ*16-1:0]           o_grant_cnt,
`endif
  output logic                            o_error
);

  localparam int unsigned DW    = DATA_SIZE + 1;
  localparam int unsigned TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [TAG_W-1:0]          ptr_q;
  logic [TAG_W-1:0]          ptr_d;
  logic [NUM_REQ-1:0]        grant;
  logic [TAG_W-1:0]          gidx;
  logic                      found;
  logic [DW-1:0]             sel_data;

  logic [DW-1:0]             sqrt_data_q;
  logic                      sqrt_vld_q;
  logic [TAG_W-1:0]          issue_tag_q;
  logic [SQRT_LATENCY-1:0]   tag_v_q;
  logic [TAG_W-1:0]          tag_q [SQRT_LATENCY];
  logic                      head_v;
  logic [TAG_W-1:0]          head_tag;
  logic [NUM_REQ*ROOT_W-1:0] res_q;
  logic [NUM_REQ-1:0]        res_vld_q;
  logic                      err_q;

  // Two-pass scan: requesters at or above the pointer first, then the wrapped ones.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && (k >= 32'(ptr_q)) && i_req_valid[k]) begin
        found    = 1'b1;
        gidx     = TAG_W'(k);
        grant    = '0;
        grant[k] = 1'b1;
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && (k < 32'(ptr_q)) && i_req_valid[k]) begin
        found    = 1'b1;
        gidx     = TAG_W'(k);
        grant    = '0;
        grant[k] = 1'b1;
      end
    end
    if (!i_reset_n) begin
      grant = '0;
      found = 1'b0;
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) sel_data = i_req_data[k*DW +: DW];
    end
  end

  assign ptr_d    = (gidx == TAG_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  assign head_v   = tag_v_q[SQRT_LATENCY-1];
  assign head_tag = tag_q[SQRT_LATENCY-1];

  // Entry 0 is fed from the issue register, so the tag trails the radicand by one
  // stage and the head lines up with the root strobe SQRT_LATENCY cycles later.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ptr_q       <= '0;
      sqrt_data_q <= '0;
      sqrt_vld_q  <= 1'b0;
      tag_v_q     <= '0;
      res_q       <= '0;
      res_vld_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      sqrt_vld_q <= found;
      if (found) begin
        ptr_q       <= ptr_d;
        sqrt_data_q <= sel_data;
      end
      tag_v_q[0] <= sqrt_vld_q;
      for (int unsigned i = 1; i < SQRT_LATENCY; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
      end
      res_vld_q <= '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (head_v && i_sqrt_data_ready && (head_tag == TAG_W'(k))) begin
          res_vld_q[k]                <= 1'b1;
          res_q[k*ROOT_W +: ROOT_W]   <= i_sqrt_data;
        end
      end
      if (head_v ^ i_sqrt_data_ready) err_q <= 1'b1;
    end
  end

  // Tag payload needs no reset: it is only consumed when its valid bit is set.
  always_ff @(posedge i_clk) begin
    if (found) issue_tag_q <= gidx;
    tag_q[0] <= issue_tag_q;
    for (int unsigned i = 1; i < SQRT_LATENCY; i++) begin
      tag_q[i] <= tag_q[i-1];
    end
  end

`ifdef SQRT_SHARE_ARB_GRANT_CNT_EN
  logic [15:0] gcnt_q [NUM_REQ];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) gcnt_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (grant[k] && (gcnt_q[k] != 16'hFFFF)) gcnt_q[k] <= gcnt_q[k] + 16'd1;
      end
    end
  end

  always_comb begin
    o_grant_cnt = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) o_grant_cnt[k*16 +: 16] = gcnt_q[k];
  end
`endif

  assign o_req_ready       = grant;
  assign o_sqrt_data       = sqrt_data_q;
  assign o_sqrt_data_ready = sqrt_vld_q;
  assign o_res_data        = res_q;
  assign o_res_valid       = res_vld_q;
  assign o_error           = err_q;

endmodule

// File: doc/sqrt_share_arbiter.md
Name: sqrt_share_arbiter

Overview:
- Shares one pipelined `sqrt` instance (fixed latency, no backpressure) between NUM_REQ requesters, e.g. the per-colour-channel gradient magnitude paths.
- Grants one requester per cycle by round-robin and drives the sqrt input.
- Carries a requester tag alongside the sqrt pipeline and steers each root back to its owner as a one-cycle valid pulse.
- Checks that sqrt output strobes line up with the tag pipeline.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_SIZE, 17, MSB index of the radicand; radicand width is DATA_SIZE+1 (must be odd, so width is even).
- SQRT_LATENCY, (DATA_SIZE+1)/2, cycles from `o_sqrt_data_ready` to matching `i_sqrt_data_ready`.
- ROOT_W, (DATA_SIZE+1)/2, root width.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  synchronous reset, active-low.
- i_req_data  in  NUM_REQ*(DATA_SIZE+1)  radicands; requester k occupies slice k.
- i_req_valid  in  NUM_REQ  requester k has a radicand.
- o_req_ready  out  NUM_REQ  one-hot grant; transfer when valid&ready.
- o_sqrt_data  out  DATA_SIZE+1  radicand to sqrt.
- o_sqrt_data_ready  out  1  radicand-valid strobe to sqrt.
- i_sqrt_data  in  ROOT_W  root from sqrt.
- i_sqrt_data_ready  in  1  root-valid strobe from sqrt.
- o_res_data  out  NUM_REQ*ROOT_W  per-requester result register; slice k.
- o_res_valid  out  NUM_REQ  one-cycle pulse: slice k updated.
- o_error  out  1  sticky tag/strobe mismatch flag.

Behaviour:
- Reset (i_reset_n=0 at posedge):
  - All outputs go to 0: `o_sqrt_data`, `o_sqrt_data_ready`, `o_res_data`, `o_res_valid`, `o_error`.
  - Round-robin pointer goes to 0, so requester 0 has highest priority.
  - All tag-pipeline valid bits are cleared.
  - `o_req_ready` is forced to 0 while i_reset_n=0.
- Grant:
  - Combinational `o_req_ready`: at most one bit set, for the first requester with `i_req_valid`=1 scanning from pointer upward with wrap at NUM_REQ.
  - No `i_req_valid` set gives `o_req_ready`=0.
  - `o_req_ready` must not combinationally depend on `i_sqrt_*`.
- Pointer update:
  - On a transfer by requester g, the pointer becomes (g+1) mod NUM_REQ.
  - With no transfer, the pointer holds.
- Issue:
  - Transfer at cycle T: `o_sqrt_data`=slice g and `o_sqrt_data_ready`=1 at T+1.
  - Otherwise `o_sqrt_data_ready`=0 and `o_sqrt_data` holds its last value.
- Throughput: one radicand per cycle aggregate, sustained indefinitely.
- Tag pipeline:
  - Shift register, SQRT_LATENCY deep, of {valid, tag[clog2(NUM_REQ)-1:0]}.
  - Entry 0 is loaded at T+1 with {1,g}, or {0,x} if nothing was issued.
  - Shifts every cycle; the head is aligned with `i_sqrt_data_ready` at T+1+SQRT_LATENCY.
- Return:
  - When head.valid & `i_sqrt_data_ready`, at the next edge: slice[head.tag] of `o_res_data` = `i_sqrt_data` and `o_res_valid`[head.tag]=1 for one cycle.
  - Other slices hold their values; all other `o_res_valid` bits are 0.
- Latency: transfer at T gives `o_res_valid` at T+2+SQRT_LATENCY.
- Ordering: results for the same requester return in issue order.
- Mismatch: head.valid XOR `i_sqrt_data_ready` sets `o_error`=1 at the next edge.
  - `o_error` stays 1 until reset.
  - A strobe without a valid tag is dropped; a valid tag without a strobe produces no result.
- Reset mid-operation: in-flight tags are discarded and no `o_res_valid` fires for them. The sqrt instance shares i_reset_n.
- Width rules:
  - The root is ROOT_W bits, no rounding (floor).
  - Max radicand 2^(DATA_SIZE+1)-1 gives root 2^ROOT_W-1 (511 at defaults).

Optional Feature:
- SQRT_SHARE_ARB_GRANT_CNT_EN defined:
  - Adds output port `o_grant_cnt`, NUM_REQ*16 bits.
  - Per-requester 16-bit counter increments on each transfer and saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: port and counters are absent; all other behaviour is identical.

Test Plan:
- Single request: requester 1 sends 144 at T (pointer 0) -> `o_sqrt_data_ready` at T+1 with 144; `o_res_valid`=3'b010 with slice1=12 at T+11 (defaults); pointer becomes 2.
- All three valid continuously with 100/49/262143 -> grants rotate 0,1,2,0,... one per cycle; results 10/7/511 return in the same rotation, one per cycle, no gaps.
- Requester 2 alone valid for 5 cycles with 0,1,2,3,4 -> 5 back-to-back transfers; roots 0,1,1,1,2 to slice 2 in order; other slices unchanged.
- Injected mismatch: bench-model sqrt asserts `i_sqrt_data_ready` one cycle early -> `o_error`=1 and stays 1; deasserts only after `i_reset_n` low for one edge.
- Reset mid-flight: issue 4 requests, pull `i_reset_n` low for 1 cycle at T+3 -> no `o_res_valid` afterwards, outputs 0, next request is granted to requester 0 first.
- With SQRT_SHARE_ARB_GRANT_CNT_EN: 70000 transfers from requester 0 -> `o_grant_cnt` slice 0 = 16'hFFFF; others 0.
